// File: rtl/audio_codec_cfg_sequencer.sv
// rtl/audio_codec_cfg_sequencer.sv - I2C master that loads the WM8731 init table and runtime volume writes
//
// Purpose:
//   Drives the codec's two-wire configuration bus (SCLK push-pull, SDAT
//   open-drain). A start pulse writes an 8-word init table; once that has
//   been acknowledged, headphone-volume words are accepted over a
//   valid/ready handshake. NACKed words are resent up to MAX_RETRY times
//   before the sticky error flag is raised.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        1-cycle pulse, (re)runs the init table from entry 0 when idle
//   vol_valid    runtime volume request valid
//   vol_data     headphone volume (7'h79 = 0 dB)
//   vol_ready    volume request can be accepted this cycle
//   i2c_sclk     SCLK output
//   i2c_sdat_oe  1 = pull SDAT low, 0 = release
//   i2c_sdat_in  SDAT pad readback
//   busy         a transaction or the init sequence is in progress
//   init_done    all init words acknowledged (sticky until reset/start)
//   err          a word failed MAX_RETRY+1 times (sticky until reset/start)

module audio_codec_cfg_sequencer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned I2C_HZ    = 100_000,
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       vol_valid,
  input  logic [6:0] vol_data,
  output logic       vol_ready,
  output logic       i2c_sclk,
  output logic       i2c_sdat_oe,
  input  logic       i2c_sdat_in,
  output logic       busy,
  output logic       init_done,
  output logic       err
);

  // Cycles per quarter bit; the quarter counter needs QUARTER >= 2 because
  // the LOAD cycle is folded into the first quarter of the START condition.
  localparam int unsigned QUARTER = CLK_HZ / (4 * I2C_HZ);
  localparam int unsigned QW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int unsigned RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_BYTE  = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;
  localparam logic [2:0] S_NEXT  = 3'd7;

  // Init table entries, {reg[6:0], data[8:0]}.
  function automatic logic [15:0] init_word(input logic [2:0] i);
    case (i)
      3'd0:    init_word = 16'h1E00;  // reset
      3'd1:    init_word = 16'h0C00;  // power down control: all on
      3'd2:    init_word = 16'h0810;  // analog path: DAC select
      3'd3:    init_word = 16'h0A00;  // digital path: unmute DAC
      3'd4:    init_word = 16'h0E02;  // interface: I2S, slave, 16 bit
      3'd5:    init_word = 16'h1000;  // sampling: 48 kHz normal mode
      3'd6:    init_word = 16'h0579;  // headphone volume 0 dB
      default: init_word = 16'h1201;  // activate
    endcase
  endfunction

  logic [2:0]    state;
  logic [QW-1:0] qcnt;
  logic [1:0]    qph;
  logic [2:0]    bitn;
  logic [1:0]    byten;
  logic [15:0]   word;
  logic [6:0]    vol_hold;
  logic [2:0]    idx;
  logic [RW-1:0] retry;
  logic          nacked;
  logic          init_mode;

  logic          tick;
  logic          last_q;
  logic          accept;
  logic          retry_ok;
  logic          more_words;

  logic [2:0]    nxt_state;
  logic [1:0]    nxt_qph;
  logic [2:0]    nxt_bitn;
  logic [1:0]    nxt_byten;
  logic [7:0]    nxt_byte;
  logic          nxt_bit;
  logic          nxt_sclk;
  logic          nxt_oe;

  assign tick       = (qcnt == QW'(QUARTER - 1));
  assign vol_ready  = (state == S_IDLE) && init_done && !err;
  assign busy       = (state != S_IDLE);
  assign accept     = vol_valid && vol_ready;
  assign retry_ok   = (retry < RW'(MAX_RETRY));
  assign more_words = init_mode && (idx != 3'd7);

  // GAP is three quarters and NEXT is the fourth bus-idle quarter, so the
  // retry/advance decision lands on the last tick of the 120-quarter word
  // slot and back-to-back words leave no dead cycles.
  assign last_q = (state == S_NEXT) ||
                  ((state == S_GAP) ? (qph == 2'd2) : (qph == 2'd3));

  always_comb begin
    nxt_state = state;
    nxt_qph   = qph;
    nxt_bitn  = bitn;
    nxt_byten = byten;
    case (state)
      S_IDLE: begin
        if (start || accept) begin
          nxt_state = S_LOAD;
        end
      end
      S_LOAD: begin
        nxt_state = S_START;
        nxt_qph   = 2'd0;
      end
      default: begin
        if (tick) begin
          if (!last_q) begin
            nxt_qph = qph + 2'd1;
          end else begin
            nxt_qph = 2'd0;
            case (state)
              S_START: begin
                nxt_state = S_BYTE;
                nxt_bitn  = 3'd0;
                nxt_byten = 2'd0;
              end
              S_BYTE: begin
                if (bitn == 3'd7) begin
                  nxt_state = S_ACK;
                end else begin
                  nxt_bitn = bitn + 3'd1;
                end
              end
              S_ACK: begin
                // A NACK on any byte abandons the rest of the word.
                if (nacked || (byten == 2'd2)) begin
                  nxt_state = S_STOP;
                end else begin
                  nxt_state = S_BYTE;
                  nxt_bitn  = 3'd0;
                  nxt_byten = byten + 2'd1;
                end
              end
              S_STOP:  nxt_state = S_GAP;
              S_GAP:   nxt_state = S_NEXT;
              S_NEXT:  nxt_state = (nacked ? retry_ok : more_words) ? S_START : S_IDLE;
              default: nxt_state = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Pad levels for the quarter being entered; registered so SCLK/SDAT
  // never glitch and every bus change happens on a quarter boundary.
  always_comb begin
    case (nxt_byten)
      2'd0:    nxt_byte = {DEV_ADDR, 1'b0};
      2'd1:    nxt_byte = word[15:8];
      default: nxt_byte = word[7:0];
    endcase
    nxt_bit  = nxt_byte[3'd7 - nxt_bitn];
    nxt_sclk = 1'b1;
    nxt_oe   = 1'b0;
    case (nxt_state)
      S_START: begin
        // q0 idle, q1 SDA falls under high SCL, q3 SCL drops.
        nxt_sclk = (nxt_qph != 2'd3);
        nxt_oe   = (nxt_qph != 2'd0);
      end
      S_BYTE: begin
        nxt_sclk = (nxt_qph == 2'd1) || (nxt_qph == 2'd2);
        nxt_oe   = !nxt_bit;
      end
      S_ACK: begin
        nxt_sclk = (nxt_qph == 2'd1) || (nxt_qph == 2'd2);
        nxt_oe   = 1'b0;
      end
      S_STOP: begin
        // q0 SDA low under low SCL, q1 SCL rises, q2 SDA released.
        nxt_sclk = (nxt_qph != 2'd0);
        nxt_oe   = (nxt_qph < 2'd2);
      end
      default: begin
        nxt_sclk = 1'b1;
        nxt_oe   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      qcnt        <= '0;
      qph         <= 2'd0;
      bitn        <= 3'd0;
      byten       <= 2'd0;
      word        <= 16'h0000;
      vol_hold    <= 7'h00;
      idx         <= 3'd0;
      retry       <= '0;
      nacked      <= 1'b0;
      init_mode   <= 1'b0;
      init_done   <= 1'b0;
      err         <= 1'b0;
      i2c_sclk    <= 1'b1;
      i2c_sdat_oe <= 1'b0;
    end else begin
      state       <= nxt_state;
      qph         <= nxt_qph;
      bitn        <= nxt_bitn;
      byten       <= nxt_byten;
      i2c_sclk    <= nxt_sclk;
      i2c_sdat_oe <= nxt_oe;

      // LOAD counts as the first cycle of START q0, keeping each word slot
      // at exactly 120 quarters measured from LOAD.
      if (state == S_IDLE) begin
        qcnt <= '0;
      end else if (state == S_LOAD) begin
        qcnt <= QW'(1);
      end else if (tick) begin
        qcnt <= '0;
      end else begin
        qcnt <= qcnt + QW'(1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            init_mode <= 1'b1;
            idx       <= 3'd0;
            retry     <= '0;
            err       <= 1'b0;
            init_done <= 1'b0;
          end else if (accept) begin
            init_mode <= 1'b0;
            retry     <= '0;
            vol_hold  <= vol_data;
          end
        end
        S_LOAD: begin
          word   <= init_mode ? init_word(idx) : {7'h02, 1'b1, 1'b0, vol_hold};
          nacked <= 1'b0;
        end
        S_ACK: begin
          if (tick && (qph == 2'd2)) begin
            nacked <= i2c_sdat_in;
          end
        end
        S_NEXT: begin
          if (tick) begin
            if (nacked) begin
              if (retry_ok) begin
                retry <= retry + RW'(1);
              end else begin
                err <= 1'b1;
              end
            end else begin
              retry <= '0;
              if (more_words) begin
                idx  <= idx + 3'd1;
                word <= init_word(idx + 3'd1);
              end else if (init_mode) begin
                init_done <= 1'b1;
              end
            end
            nacked <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_codec_cfg_sequencer.sv
// tb/tb_audio_codec_cfg_sequencer.sv - directed bench for audio_codec_cfg_sequencer with a WM8731 bus model

module tb_audio_codec_cfg_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       vol_valid = 1'b0;
  logic [6:0] vol_data = 7'h00;
  logic       vol_ready;
  logic       i2c_sclk;
  logic       i2c_sdat_oe;
  logic       i2c_sdat_in;
  logic       busy;
  logic       init_done;
  logic       err;

  int passed = 0;
  int fails = 0;
  int total = 0;

  always #5 clk = ~clk;

  audio_codec_cfg_sequencer #(
    .CLK_HZ   (800_000),
    .I2C_HZ   (100_000),
    .DEV_ADDR (7'h1A),
    .MAX_RETRY(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .vol_valid  (vol_valid),
    .vol_data   (vol_data),
    .vol_ready  (vol_ready),
    .i2c_sclk   (i2c_sclk),
    .i2c_sdat_oe(i2c_sdat_oe),
    .i2c_sdat_in(i2c_sdat_in),
    .busy       (busy),
    .init_done  (init_done),
    .err        (err)
  );

  // Codec bus model: decodes START/STOP, shifts bits on SCL rise, drives
  // ACK after the 8th bit. Each frame is logged at STOP as
  // {byte count[1:0], b0, b1, b2}.
  logic        codec_pull = 1'b0;
  logic        prev_scl = 1'b1;
  logic        prev_msda = 1'b1;
  logic        in_frame = 1'b0;
  logic        acking = 1'b0;
  int          bitcnt = 0;
  int          bytecnt = 0;
  logic [7:0]  shreg = 8'h00;
  logic [7:0]  fb [3];
  logic [25:0] txlog [$];
  logic        nack_addr_always = 1'b0;
  logic        nack_once_req = 1'b0;
  logic        nack_once_used = 1'b0;

  assign i2c_sdat_in = !(i2c_sdat_oe || codec_pull);

  always @(negedge clk) begin : codec_model
    logic msda;
    logic nack;
    msda = !i2c_sdat_oe;
    if (reset) begin
      prev_scl   = 1'b1;
      prev_msda  = 1'b1;
      in_frame   = 1'b0;
      acking     = 1'b0;
      codec_pull = 1'b0;
    end else begin
      if (prev_scl && i2c_sclk && prev_msda && !msda) begin
        in_frame = 1'b1;
        bitcnt   = 0;
        bytecnt  = 0;
        acking   = 1'b0;
        fb[0] = 8'h00; fb[1] = 8'h00; fb[2] = 8'h00;
      end else if (prev_scl && i2c_sclk && !prev_msda && msda) begin
        if (in_frame) txlog.push_back({2'(bytecnt), fb[0], fb[1], fb[2]});
        in_frame   = 1'b0;
        codec_pull = 1'b0;
      end else if (in_frame && !prev_scl && i2c_sclk) begin
        if (bitcnt < 8) begin
          shreg  = {shreg[6:0], msda};
          bitcnt = bitcnt + 1;
        end
      end else if (in_frame && prev_scl && !i2c_sclk) begin
        if (acking) begin
          codec_pull = 1'b0;
          acking     = 1'b0;
          bitcnt     = 0;
          bytecnt    = bytecnt + 1;
        end else if (bitcnt == 8) begin
          if (bytecnt < 3) fb[bytecnt] = shreg;
          nack = (bytecnt == 0 && (shreg != 8'h34 || nack_addr_always));
          if (nack_once_req && !nack_once_used && bytecnt == 1 && shreg == 8'h0A) begin
            nack = 1'b1;
            nack_once_used = 1'b1;
          end
          codec_pull = !nack;
          acking     = 1'b1;
        end
      end
      prev_scl  = i2c_sclk;
      prev_msda = msda;
    end
  end

  logic [15:0] tbl [8] = '{16'h1E00, 16'h0C00, 16'h0810, 16'h0A00,
                           16'h0E02, 16'h1000, 16'h0579, 16'h1201};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] full_rec(input logic [15:0] w);
    return {2'd3, 8'h34, w};
  endfunction

  function automatic logic [25:0] log_at(input int i);
    if (i < txlog.size()) return txlog[i];
    return 26'h0;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_init_done(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_table(input int base, input string tag);
    for (int i = 0; i < 8; i++) check(tag, log_at(base + i), full_rec(tbl[i]));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int base;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sclk", i2c_sclk, 1);
    check("rst_oe", i2c_sdat_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_init_done", init_done, 0);
    check("rst_err", err, 0);
    check("rst_vol_ready", vol_ready, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: full init table
    base = txlog.size();
    pulse_start();
    check("t1_busy", busy, 1);
    wait_init_done(n);
    check("t1_cycles", n, 1920);
    check("t1_busy_low", busy, 0);
    check("t1_err", err, 0);
    check("t1_vol_ready", vol_ready, 1);
    check("t1_nrec", txlog.size() - base, 8);
    check_table(base, "t1_rec");

    // 2: one NACK on the second byte of entry 3
    nack_once_req = 1'b1;
    base = txlog.size();
    pulse_start();
    check("t2_init_clr", init_done, 0);
    wait_init_done(n);
    check("t2_cycles", n, 2088);
    check("t2_err", err, 0);
    check("t2_nrec", txlog.size() - base, 9);
    for (int i = 0; i < 3; i++) check("t2_rec_pre", log_at(base + i), full_rec(tbl[i]));
    check("t2_rec_nack", log_at(base + 3), {2'd2, 8'h34, 8'h0A, 8'h00});
    for (int i = 3; i < 8; i++) check("t2_rec_post", log_at(base + i + 1), full_rec(tbl[i]));

    // 3: address always NACKed
    nack_addr_always = 1'b1;
    base = txlog.size();
    pulse_start();
    wait_idle(n);
    check("t3_cycles", n, 384);
    check("t3_err", err, 1);
    check("t3_init_done", init_done, 0);
    check("t3_vol_ready", vol_ready, 0);
    check("t3_nrec", txlog.size() - base, 4);
    for (int i = 0; i < 4; i++) check("t3_rec", log_at(base + i), {2'd1, 8'h34, 16'h0000});
    nack_addr_always = 1'b0;
    base = txlog.size();
    pulse_start();
    check("t3_err_clr", err, 0);
    wait_init_done(n);
    check("t3_rerun_cycles", n, 1920);
    check_table(base, "t3_rerun_rec");

    // 4: runtime volume write
    base = txlog.size();
    vol_valid = 1'b1;
    vol_data  = 7'h30;
    @(negedge clk);
    check("t4_ready_drop", vol_ready, 0);
    check("t4_busy", busy, 1);
    vol_valid = 1'b0;
    wait_idle(n);
    check("t4_cycles", n, 240);
    check("t4_nrec", txlog.size() - base, 1);
    check("t4_rec", log_at(base), {2'd3, 8'h34, 8'h05, 8'h30});
    check("t4_ready_back", vol_ready, 1);

    // 5: reset at quarter 50 of the first word (byte 1E, bit 5 = 0, SCL high)
    pulse_start();
    repeat (100) @(negedge clk);
    check("t5_pre_sclk", i2c_sclk, 1);
    check("t5_pre_oe", i2c_sdat_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_sclk", i2c_sclk, 1);
    check("t5_oe", i2c_sdat_oe, 0);
    check("t5_busy", busy, 0);
    check("t5_init_done", init_done, 0);
    check("t5_err", err, 0);
    check("t5_vol_ready", vol_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    base = txlog.size();
    pulse_start();
    wait_init_done(n);
    check("t5_cycles", n, 1920);
    check("t5_idx0", log_at(base), full_rec(16'h1E00));

    // 6: start and vol_valid together -> start wins, volume after new init
    base = txlog.size();
    start     = 1'b1;
    vol_valid = 1'b1;
    vol_data  = 7'h55;
    @(negedge clk);
    start = 1'b0;
    check("t6_busy", busy, 1);
    check("t6_init_clr", init_done, 0);
    wait_init_done(n);
    check("t6_cycles", n, 1920);
    @(negedge clk);
    check("t6_accept", vol_ready, 0);
    check("t6_busy_vol", busy, 1);
    vol_valid = 1'b0;
    wait_idle(n);
    check("t6_vol_cycles", n, 240);
    check("t6_nrec", txlog.size() - base, 9);
    check("t6_first", log_at(base), full_rec(16'h1E00));
    check("t6_vol", log_at(base + 8), {2'd3, 8'h34, 8'h05, 8'h55});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
